// File: rtl/arb_pkg.sv
// Shared types and constants for the 3-way request/select arbiter.
// No logic here; the helper function is pure combinational index arithmetic.
// No flow control; consumers decide how the values are registered.
package arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] GNT_R0   = 2'b00;
  localparam logic [1:0] GNT_R1   = 2'b01;
  localparam logic [1:0] GNT_R2   = 2'b10;
  localparam logic [1:0] GNT_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Requester index reached by stepping ofs places from start, wrapping 2->0.
  function automatic logic [1:0] wrap_idx(input logic [1:0] start, input logic [1:0] ofs);
    logic [2:0] w_sum;
    w_sum = {1'b0, start} + {1'b0, ofs};
    if (w_sum >= 3'(NUM_REQ)) w_sum = w_sum - 3'(NUM_REQ);
    return w_sum[1:0];
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Picks one winner from a request vector, searching upward from a start index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; o_vld is low when the request vector is empty.
module arb_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_start,
  output logic [NUM_REQ-1:0] o_win,
  output logic [1:0]         o_code,
  output logic               o_vld
);

  // First set request found walking start, start+1, start+2 (mod 3) wins.
  always_comb begin
    o_win  = '0;
    o_code = GNT_NONE;
    o_vld  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_vld && i_req[wrap_idx(i_start, 2'(k))]) begin
        o_vld                          = 1'b1;
        o_win[wrap_idx(i_start, 2'(k))] = 1'b1;
        o_code                         = wrap_idx(i_start, 2'(k));
      end
    end
  end

endmodule

// File: rtl/req_sel_arbiter.sv
// Shares one resource among 3 requesters; grant held until release or MAX_HOLD timeout.
// Latency: grant 1 edge after request seen in IDLE; 2-edge dead gap between grants.
// Backpressure: owners keep req high to hold; ARB_ROUND_ROBIN_EN selects rotating priority.
module req_sel_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  output logic [2:0]   gnt,
  output logic [1:0]   gnt_code,
  output logic         busy,
  output logic         timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t         r_state;
  logic [2:0]         r_gnt;
  logic [1:0]         r_gnt_code;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [1:0]         r_last_owner;
  logic [2:0]         r_mask;

  logic [2:0]         w_elig;
  logic [2:0]         w_arb_req;
  logic [1:0]         w_start;
  logic [2:0]         w_win;
  logic [1:0]         w_code;
  logic               w_vld;
  logic               w_owner_req;

  // A timed-out requester sits out one arbitration unless it is the only one asking.
  always_comb begin
    w_elig    = req & ~r_mask;
    w_arb_req = (|w_elig) ? w_elig : req;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Search begins just after whoever was granted last.
  always_comb begin
    w_start = wrap_idx(r_last_owner, 2'd1);
  end
`else
  logic w_unused_last_owner;

  // Fixed priority: always search from requester 0; last owner is tracked but ignored.
  always_comb begin
    w_start             = 2'd0;
    w_unused_last_owner = ^r_last_owner;
  end
`endif

  arb_pick u_pick (
    .i_req   (w_arb_req),
    .i_start (w_start),
    .o_win   (w_win),
    .o_code  (w_code),
    .o_vld   (w_vld)
  );

  // The owner's request is still up if it overlaps the current one-hot grant.
  assign w_owner_req = |(req & r_gnt);

  // Grant FSM: IDLE arbitrates, BUSY holds until release/timeout, RELEASE is the dead cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 3'b000;
      r_gnt_code   <= GNT_NONE;
      r_timeout    <= 1'b0;
      r_hold_cnt   <= '0;
      r_last_owner <= 2'd2;
      r_mask       <= 3'b000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_state      <= ST_BUSY;
            r_gnt        <= w_win;
            r_gnt_code   <= w_code;
            r_hold_cnt   <= '0;
            r_last_owner <= w_code;
            r_mask       <= 3'b000;
          end
        end
        ST_BUSY: begin
          if (!w_owner_req) begin
            // Normal release takes precedence over a coincident timeout.
            r_state    <= ST_RELEASE;
            r_gnt      <= 3'b000;
            r_gnt_code <= GNT_NONE;
            r_mask     <= 3'b000;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RELEASE;
            r_gnt      <= 3'b000;
            r_gnt_code <= GNT_NONE;
            r_timeout  <= 1'b1;
            r_mask     <= r_gnt;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          r_state   <= ST_IDLE;
          r_timeout <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_gnt      <= 3'b000;
          r_gnt_code <= GNT_NONE;
          r_timeout  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign gnt_code = r_gnt_code;
  assign timeout  = r_timeout;
  assign busy     = (r_state == ST_BUSY);

endmodule

// File: tb/tb_req_sel_arbiter.sv
// Scoreboard bench for req_sel_arbiter: a reference model predicts each cycle's outputs.
// Expected values are queued at stimulus time and popped by an independent monitor.
// MAX_HOLD is 4 so timeouts occur frequently under random stimulus.
module tb_req_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] gnt;
  logic [1:0] gnt_code;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected {gnt, gnt_code, busy, timeout}
  logic [6:0] exp_q[$];

  // Reference model state
  int m_owner  = -1;  // current owner index, -1 when none
  int m_held   = 0;   // cycles the current owner has held the grant
  int m_gap    = 0;   // 1 while in the dead cycle after a grant ends
  int m_to     = 0;
  int m_masked = -1;  // requester excluded from the next grant decision
  int m_last   = 2;

  req_sel_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_code (gnt_code),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic int choose(input logic [2:0] cand, input int last);
    int idx;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (cand[idx]) return idx;
    end
`else
    idx = last;  // rotation state has no effect in fixed-priority mode
    for (int k = 0; k < 3; k++) if (cand[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] q);
    logic [2:0] cand;
    logic [6:0] e;
    if (r) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_to = 0; m_masked = -1; m_last = 2;
    end else if (m_gap != 0) begin
      m_gap = 0;
      m_to  = 0;
    end else if (m_owner < 0) begin
      cand = q;
      if (m_masked >= 0) cand[m_masked] = 1'b0;
      if (cand == 3'b000) cand = q;
      if (cand != 3'b000) begin
        m_owner  = choose(cand, m_last);
        m_last   = m_owner;
        m_held   = 1;
        m_masked = -1;
      end
    end else begin
      if (!q[m_owner]) begin
        m_owner = -1; m_gap = 1; m_masked = -1;
      end else if (m_held == HOLD) begin
        m_masked = m_owner; m_owner = -1; m_gap = 1; m_to = 1;
      end else begin
        m_held++;
      end
    end
    e[6:4] = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    e[3:2] = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
    e[1]   = (m_owner >= 0);
    e[0]   = (m_to != 0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [2:0] q, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r;
      req = q;
      model_step(r, q);
    end
  endtask

  // Monitor: compares every registered output set just after the edge.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({gnt, gnt_code, busy, timeout} !== e) begin
          n_fail++;
          $display("FAIL outputs cyc%0d: got gnt=%b code=%b busy=%b timeout=%b, want gnt=%b code=%b busy=%b timeout=%b",
                   cyc, gnt, gnt_code, busy, timeout, e[6:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    // Reset held with all requests up
    drive(1'b1, 3'b111, 2);
    drive(1'b0, 3'b111, 1);
    drive(1'b0, 3'b000, 3);
    // Fixed priority / handover after release
    drive(1'b0, 3'b110, 2);
    drive(1'b0, 3'b100, 4);
    drive(1'b0, 3'b000, 3);
    // Timeout with competitor, masked regrant, then return to requester 0
    drive(1'b0, 3'b011, 8);
    drive(1'b0, 3'b001, 4);
    drive(1'b0, 3'b000, 3);
    // Lone requester times out and is regranted
    drive(1'b0, 3'b001, 9);
    drive(1'b0, 3'b000, 3);
    // Owner drops on the cycle the timeout would fire
    drive(1'b0, 3'b001, 4);
    drive(1'b0, 3'b000, 3);
    // Reset mid-grant
    drive(1'b0, 3'b100, 2);
    drive(1'b1, 3'b100, 1);
    drive(1'b0, 3'b000, 2);
    // All requesting, owner releases after one cycle of grant
    for (int i = 0; i < 16; i++) begin
      if (m_owner >= 0 && m_held >= 1) drive(1'b0, 3'b111 & ~3'(1 << m_owner), 1);
      else drive(1'b0, 3'b111, 1);
    end
    drive(1'b0, 3'b000, 3);
    // Random traffic with sticky requests and occasional reset
    begin
      logic [2:0] q;
      logic       r;
      q = 3'b000;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) q[$urandom_range(0, 2)] ^= 1'b1;
        r = ($urandom_range(0, 199) == 0);
        drive(r, q, 1);
      end
    end
    drive(1'b0, 3'b000, 3);
    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/req_sel_arbiter.md
Name: req_sel_arbiter

Overview:
- Sequential arbiter sharing one resource (bus/port, e.g. a memory or regfile write port) among 3 requesters.
- Emits a one-hot grant and a 2-bit grant code: 00 = req[0], 01 = req[1], 10 = req[2], 11 = none.
- Grants are held until the owner releases its request or a hold timeout fires.
- Sits between requesting pipeline units and the shared-resource mux, and drives that mux's select directly from gnt_code.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold a grant; legal range 2..255.
- CNT_W, $clog2(MAX_HOLD): hold counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request lines; req[i] is held high while requester i wants the resource.
- gnt  output  3  registered one-hot grant; all zero when no owner.
- gnt_code  output  2  registered encoded grant: 00/01/10 = owner 0/1/2, 11 = none.
- busy  output  1  high while state is BUSY.
- timeout  output  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset:
  - rst is synchronous and active-high, sampled on the clk rising edge.
  - Reset forces state IDLE, gnt=000, gnt_code=11, busy=0, timeout=0, hold_cnt=0, last_owner=2, mask=000.
  - Reset mid-grant drops the grant at the same edge; there is no release cycle.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - At each edge, arbitrate over the eligible set (req & ~mask), falling back to req if that set is zero.
  - If any eligible request exists, go to BUSY. At that same edge: gnt and gnt_code take the winner, busy=1, hold_cnt=0, owner latched.
  - Grant latency: 1 edge from req sampled high.
- Priority (default build): fixed, req[0] > req[1] > req[2].
- BUSY, release:
  - If req[owner]==0 at an edge, go to RELEASE.
  - At that edge gnt=000, gnt_code=11, busy=0, mask cleared.
- BUSY, timeout:
  - Otherwise, if hold_cnt==MAX_HOLD-1, the timeout path is taken. Next state is RELEASE, with gnt=000, gnt_code=11 and busy=0.
  - The timeout path also pulses timeout=1 for exactly one cycle and sets mask to onehot(owner).
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1.
- BUSY, other requesters: requests from non-owners are ignored; there is no preemption.
- RELEASE:
  - One dead cycle on the resource. Always go to IDLE and clear timeout.
  - Minimum gap between two grants is 2 edges (release edge + RELEASE→IDLE edge).
- Mask:
  - Excludes a timed-out requester from the next arbitration only.
  - Cleared after that arbitration completes, or on a normal release.
  - If the masked requester is the only one requesting, it is granted anyway (no deadlock).
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_code is always consistent with gnt.
  - busy == (state==BUSY).
- Simultaneous events:
  - If the owner drops req on the same edge the timeout would fire, normal release wins and no timeout pulse is issued.
  - Changes on req while in RELEASE are ignored until IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: rotating priority. The search starts at (last_owner+1) mod 3 and wraps 2→0. last_owner updates on every grant. Mask rules apply unchanged on top of rotation.
- Undefined: fixed priority 0>1>2; last_owner is present but unused.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, BUSY, RELEASE}.
  - Grant-code constants GNT_R0=2'b00, GNT_R1=2'b01, GNT_R2=2'b10, GNT_NONE=2'b11.
  - NUM_REQ=3.
- One sub-module, arb_pick:
  - Purely combinational.
  - Inputs: request vector and start index.
  - Outputs: one-hot winner, encoded code and valid.
  - Fixed-priority mode ties start to 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=111 → gnt=000, gnt_code=11, busy=0 throughout. First grant to req[0] (code 00) on the edge after rst falls.
- Fixed priority: req=110 → gnt=010, code 01 after 1 edge. Owner drops req (req=100) → gnt=000 for 2 cycles, then gnt=100, code 10.
- Timeout, MAX_HOLD=4: req=011 held → gnt=001 for 4 cycles, then a single timeout pulse and RELEASE. Next grant goes to req[1] (masked req[0]). When req[1] releases, req[0] is regranted.
- Lone masked requester: req=001 held with MAX_HOLD=4 → timeout fires, then req[0] is regranted after the 2-cycle gap (no starvation deadlock).
- Release vs timeout collision: owner drops req on the timeout edge → timeout stays 0, normal release.
- ARB_ROUND_ROBIN_EN defined: req=111 with each owner releasing after 1 cycle → grant sequence 0,1,2,0, codes 00,01,10,00.
